// File: rtl/jstk_spi_responder_pkg.sv
// jstk_spi_responder_pkg: shared constants, FSM encoding and frame builder for the joystick responder
package jstk_spi_responder_pkg;
  localparam int JSTK_NUM_BYTES = 5;
  localparam int JSTK_LED_CMD_BIT = 7;
  localparam int JSTK_POS_W = 10;
  localparam int JSTK_BTN_W = 3;
  typedef enum logic [1:0] {IDLE, SHIFT, END} jstk_state_e;
  // byte0 lands in the low 8 bits so the frame can be shifted out a byte at a time
  function automatic logic [8*JSTK_NUM_BYTES-1:0] jstk_frame(
    input logic [JSTK_POS_W-1:0] x,
    input logic [JSTK_POS_W-1:0] y,
    input logic [JSTK_BTN_W-1:0] btn
  );
    return {5'b0, btn, 6'b0, y[9:8], y[7:0], 6'b0, x[9:8], x[7:0]};
  endfunction
endpackage

// File: rtl/jstk_spi_responder_if.sv
// jstk_spi_responder_if: SPI pins plus joystick value/status bundle between master side and responder
interface jstk_spi_responder_if;
  import jstk_spi_responder_pkg::*;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;
  logic [JSTK_POS_W-1:0] x_pos;
  logic [JSTK_POS_W-1:0] y_pos;
  logic [JSTK_BTN_W-1:0] btn;
  logic [1:0] led;
  logic busy;
  logic done;
  modport slave (input ss, sclk, mosi, x_pos, y_pos, btn, output miso, led, busy, done);
  modport master (output ss, sclk, mosi, x_pos, y_pos, btn, input miso, led, busy, done);
endinterface

// File: rtl/jstk_spi_responder_spi_pin_sync.sv
// spi_pin_sync: STAGES-deep synchronizer for an asynchronous pin with one-flop rise/fall detect
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign level_o = sync_q[STAGES-1];
  assign rise_o = level_o & ~prev_q;
  assign fall_o = ~level_o & prev_q;
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave emulating the PmodJSTK (X/Y/buttons out, LED command in).
// Define JSTK_RESPONDER_TRISTATE_EN to float MISO whenever no transaction is in progress.
module jstk_spi_responder
  import jstk_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic clk_i,
  input logic rst_i,
  jstk_spi_responder_if.slave bus
);
  logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi;
  logic [8*JSTK_NUM_BYTES-1:0] frame_w;
  logic [7:0] rx_d;
  jstk_state_e state_q;
  logic [8*JSTK_NUM_BYTES-9:0] frame_q;
  logic [7:0] tx_q;
  logic [6:0] rx_q;
  logic [2:0] bit_cnt_q, byte_cnt_q;
  logic miso_q, busy_q, done_q;
  logic [1:0] led_q;
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_ss (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(bus.ss), .level_o(), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(bus.sclk), .level_o(), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(bus.mosi), .level_o(mosi), .rise_o(), .fall_o()
  );
  assign frame_w = jstk_frame(bus.x_pos, bus.y_pos, bus.btn);
  assign rx_d = {rx_q, mosi};
  // frame_q drains a byte per load, so loads past byte4 naturally yield zero
  always_ff @(posedge clk_i) begin
    done_q <= 1'b0;
    if (rst_i) begin
      state_q <= IDLE;
      frame_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      bit_cnt_q <= '0;
      byte_cnt_q <= '0;
      miso_q <= 1'b0;
      led_q <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ss_fall) begin
          frame_q <= frame_w[8*JSTK_NUM_BYTES-1:8];
          tx_q <= frame_w[7:0];
          miso_q <= frame_w[7];
          bit_cnt_q <= '0;
          byte_cnt_q <= '0;
          busy_q <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: if (ss_rise) begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= END;
        end else if (sclk_rise) begin
          rx_q <= rx_d[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_q <= (byte_cnt_q == 3'(JSTK_NUM_BYTES)) ? byte_cnt_q : byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd0 && rx_d[JSTK_LED_CMD_BIT]) led_q <= rx_d[1:0];
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_q <= {tx_q[6:0], 1'b0};
            miso_q <= tx_q[6];
          end else if (byte_cnt_q != 3'd0) begin
            tx_q <= frame_q[7:0];
            miso_q <= frame_q[7];
            frame_q <= frame_q >> 8;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef JSTK_RESPONDER_TRISTATE_EN
  assign bus.miso = (state_q == SHIFT) ? miso_q : 1'bz;
`else
  assign bus.miso = miso_q;
`endif
  assign bus.led = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: randomized SPI-master bench with a frame/LED reference model
module tb_jstk_spi_responder;
  localparam int HALF = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [1:0] led_m = 2'b00;
  bit busy_bad;
`ifdef JSTK_RESPONDER_TRISTATE_EN
  logic miso_idle = 1'bz;
`else
  logic miso_idle = 1'b0;
`endif
  always #5 clk = ~clk;
  jstk_spi_responder_if bus ();
  jstk_spi_responder dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    case (k)
      0: return x[7:0];
      1: return {6'b0, x[9:8]};
      2: return y[7:0];
      3: return {6'b0, y[9:8]};
      4: return {5'b0, b};
      default: return 8'h00;
    endcase
  endfunction

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit first, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      cyc(HALF);
      rx = {rx[6:0], bus.miso};
      if (bus.busy !== 1'b1) busy_bad = 1;
      bus.sclk = 1'b1;
      if (first && i == 7) begin
        cyc(5);
        vectors++;
        if (bus.led !== led_m) begin
          errors++;
          $display("FAIL led_cmd: led=%b expected %b", bus.led, led_m);
        end
        cyc(HALF - 5);
      end else cyc(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic txn(input int nbytes, input logic [7:0] cmd, input bit change_x);
    logic [9:0] x, y;
    logic [2:0] b;
    logic [7:0] rx, tx;
    int d0;
    x = bus.x_pos;
    y = bus.y_pos;
    b = bus.btn;
    d0 = done_cnt;
    busy_bad = 0;
    if (cmd[7]) led_m = cmd[1:0];
    bus.ss = 1'b0;
    cyc(HALF);
    for (int k = 0; k < nbytes; k++) begin
      tx = (k == 0) ? cmd : 8'($urandom);
      xfer(tx, 8, k == 0, rx);
      vectors++;
      if (rx !== exp_byte(k, x, y, b)) begin
        errors++;
        $display("FAIL byte%0d: miso=%h expected %h", k, rx, exp_byte(k, x, y, b));
      end
      if (change_x && k == 0) bus.x_pos = 10'h3FF;
    end
    cyc(HALF);
    bus.ss = 1'b1;
    cyc(8);
    vectors++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d expected %0d", done_cnt - d0, 1);
    end
    vectors++;
    if (busy_bad !== 1'b0) begin
      errors++;
      $display("FAIL busy_during: busy dropped, expected 1 throughout");
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ss = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.x_pos = '0;
    bus.y_pos = '0;
    bus.btn = '0;
    cyc(4);
    vectors += 4;
    if (bus.miso !== miso_idle) begin errors++; $display("FAIL rst_miso: %b expected %b", bus.miso, miso_idle); end
    if (bus.led !== 2'b00) begin errors++; $display("FAIL rst_led: %b expected 00", bus.led); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: %b expected 0", bus.done); end
    rst = 1'b0;
    led_m = 2'b00;
    cyc(8);
  endtask

  task automatic test_full_read();
    bus.x_pos = 10'h2A5;
    bus.y_pos = 10'h13C;
    bus.btn = 3'b101;
    txn(5, 8'h00, 0);
  endtask

  task automatic test_led_cmd();
    txn(5, 8'h83, 0);
    txn(5, 8'h02, 0);
    vectors++;
    if (bus.led !== 2'b11) begin errors++; $display("FAIL led_hold: %b expected 11", bus.led); end
  endtask

  task automatic test_snapshot();
    bus.x_pos = 10'h155;
    txn(5, 8'h00, 1);
    txn(2, 8'h00, 0);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int d0;
    d0 = done_cnt;
    bus.ss = 1'b0;
    cyc(HALF);
    xfer(8'h81, 4, 0, rx);
    cyc(HALF);
    bus.ss = 1'b1;
    cyc(8);
    vectors += 2;
    if (bus.led !== led_m) begin errors++; $display("FAIL abort_led: %b expected %b", bus.led, led_m); end
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL abort_done: %0d expected 1", done_cnt - d0); end
    bus.x_pos = 10'($urandom);
    txn(5, 8'h00, 0);
  endtask

  task automatic test_overrun();
    bit bad;
    bus.x_pos = 10'($urandom);
    bus.y_pos = 10'($urandom);
    bus.btn = 3'($urandom);
    txn(7, 8'h00, 0);
    bad = 0;
    for (int p = 0; p < 3; p++) begin
      bus.sclk = 1'b1;
      for (int c = 0; c < 2 * HALF; c++) begin
        if (c == HALF) bus.sclk = 1'b0;
        cyc(1);
        if (bus.miso !== miso_idle || bus.busy !== 1'b0) bad = 1;
      end
    end
    vectors++;
    if (bad) begin errors++; $display("FAIL stray_sclk: miso/busy moved, expected %b/0", miso_idle); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      bus.x_pos = 10'($urandom);
      bus.y_pos = 10'($urandom);
      bus.btn = 3'($urandom);
      txn(int'($urandom_range(1, 7)), 8'($urandom), 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int d0;
    bus.x_pos = 10'($urandom);
    d0 = done_cnt;
    busy_bad = 0;
    led_m = 2'b10;
    bus.ss = 1'b0;
    cyc(HALF);
    xfer(8'h82, 8, 1, rx);
    xfer(8'($urandom), 8, 0, rx);
    rst = 1'b1;
    cyc(1);
    led_m = 2'b00;
    vectors += 4;
    if (bus.miso !== miso_idle) begin errors++; $display("FAIL rmid_miso: %b expected %b", bus.miso, miso_idle); end
    if (bus.led !== 2'b00) begin errors++; $display("FAIL rmid_led: %b expected 00", bus.led); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done: %b expected 0", bus.done); end
    bus.ss = 1'b1;
    bus.sclk = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(8);
    vectors++;
    if (done_cnt !== d0) begin errors++; $display("FAIL rmid_nodone: %0d pulses expected 0", done_cnt - d0); end
    txn(5, 8'h00, 0);
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_led_cmd();
    test_snapshot();
    test_abort();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI mode-0 slave that emulates the PmodJSTK joystick module at its pins. It answers the joystick master's 5-byte transaction with a 10-bit X position, a 10-bit Y position and button state, and decodes the LED command byte the master sends. It runs on the 100 MHz board clock, oversampling SS/SCLK/MOSI. Uses: loopback bench for the joystick master, and board-to-board joystick emulation.

## Interface
- SYNC_STAGES, 2: synchronizer depth on SS, SCLK and MOSI; minimum 2.
- CLK  input  1  100 MHz board clock; sole clock.
- RESET  input  1  synchronous, active-high reset.
- SS  input  1  slave select, active low, asynchronous pin.
- SCLK  input  1  serial clock from master, asynchronous pin.
- MOSI  input  1  master-out data, asynchronous pin.
- MISO  output  1  slave-out data, MSB first.
- X_POS  input  10  joystick X value; snapshotted at transaction start.
- Y_POS  input  10  joystick Y value; snapshotted at transaction start.
- BTN  input  3  button state {btn2, btn1, trigger}; snapshotted at transaction start.
- LED  output  2  last commanded LED state.
- BUSY  output  1  high while a transaction is active.
- DONE  output  1  one-CLK pulse when a transaction ends (normal or aborted).

## Operation
- Reset value of every output: MISO=0, LED=2'b00, BUSY=0, DONE=0. Reset also clears the counters and returns the FSM to IDLE.
- Reset mid-transaction: the transaction is abandoned and no LED update occurs.
- Pins pass through SYNC_STAGES flops, then a 1-flop edge detector. This yields ss_fall, ss_rise, sclk_rise and sclk_fall.
- Transmit frame (5 bytes, each MSB first):
  - byte0 = X_POS[7:0]
  - byte1 = {6'b0, X_POS[9:8]}
  - byte2 = Y_POS[7:0]
  - byte3 = {6'b0, Y_POS[9:8]}
  - byte4 = {5'b0, BTN}
- FSM states:
  - IDLE: on ss_fall, latch the 40-bit frame, load the tx shift register with byte0, present bit7 on MISO, clear bit_cnt (3 b) and byte_cnt (3 b), then go to SHIFT.
  - SHIFT, on sclk_rise: shift synchronized MOSI into the rx shift register; bit_cnt++.
  - SHIFT, on sclk_fall: drive the next tx bit.
  - SHIFT, byte boundary: when bit_cnt wraps 7→0 on a rise, byte_cnt++ (saturating at 5). The next fall loads the next frame byte.
  - SHIFT, byte_cnt==5: MISO outputs 0 for all remaining bits. Received bits are ignored.
  - SHIFT, on ss_rise: go to END.
  - END: one cycle; pulse DONE, deassert BUSY, return to IDLE.
- LED command: when received byte 0 completes with rx[7]=1, LED <= rx[1:0] on that same cycle. If rx[7]=0, LED holds. Bytes 1..4 from MOSI are discarded.
- Aborted transaction (ss_rise before byte 0 completes): no LED update. DONE still pulses.
- SCLK edges while SS is high are ignored.
- ss_fall and sclk_rise detected in the same CLK cycle: ss_fall wins, and that sclk edge is dropped. This is a master protocol violation.
- BUSY=1 in SHIFT only.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 CLK cycles (3 at default).
- MISO changes at most SYNC_STAGES+2 CLK cycles after the SCLK or SS pin edge (40 ns at default). This is well inside the 7.5 µs half-period of the master's 66.67 kHz SCLK.
- Minimum supported SCLK high/low time: SYNC_STAGES+3 CLK cycles.
- LED updates SYNC_STAGES+2 cycles after the 8th SCLK rising edge.
- DONE pulses 1 cycle after ss_rise is detected.

## Configuration
- JSTK_RESPONDER_TRISTATE_EN defined: MISO is 1'bz whenever the FSM is IDLE/END, and driven only in SHIFT.
- JSTK_RESPONDER_TRISTATE_EN undefined: MISO is driven 0 outside SHIFT.

## Structure
- Shared package holds:
  - JSTK_NUM_BYTES=5
  - JSTK_LED_CMD_BIT=7
  - JSTK_POS_W=10
  - JSTK_BTN_W=3
  - FSM state encoding (IDLE, SHIFT, END)
- One sub-module, spi_pin_sync: SYNC_STAGES-deep synchronizer plus rise/fall detect. It is instantiated three times, for SS, SCLK and MOSI (MOSI uses the level output only).

## Test plan
- Full read: X_POS=10'h2A5, Y_POS=10'h13C, BTN=3'b101, master sends 5×8'h00 → MISO bytes A5,02,3C,01,05; LED stays 00; one DONE pulse; BUSY high throughout.
- LED command: master sends first byte 8'h83 → LED=2'b11 within 5 CLK of the 8th SCLK rise. Then first byte 8'h02 in a new transaction → LED stays 2'b11.
- Snapshot: change X_POS to 10'h3FF mid-transaction → bytes still reflect the value at ss_fall. The next transaction returns FF,03.
- Abort: SS rises after 4 bits of byte 0 carrying 8'h81 → LED unchanged, DONE pulses, and the next transaction starts cleanly with byte0 correct.
- Overrun: 7-byte transaction → bytes 6–7 read 00, no hang. Stray SCLK pulses with SS high → no MISO change, BUSY stays 0.
- Reset mid-transaction after byte 2 → all outputs return to their reset values the next cycle. With JSTK_RESPONDER_TRISTATE_EN defined, MISO is Z while idle.
